// File: rtl/regfile_2w_scoreboard.sv
// Two-read / two-write register file with a per-register pending-write scoreboard.
// Port 4 (load return) wins write conflicts and retires busy bits; CLAIM marks a register pending.
module regfile_2w_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              CLAIM,
  input  logic [ADDR_W-1:0] CA,
  output logic              BUSY_ANY
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Bypass order mirrors write priority: port 4 data beats port 3 data.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] d;
    d = stored;
    if (is_zero(a))
      d = '0;
    else if ((BYPASS != 0) && WE4 && (A4 == a))
      d = WD4;
    else if ((BYPASS != 0) && WE3 && (A3 == a))
      d = WD3;
    return d;
  endfunction

  function automatic logic busy_sel(input logic [ADDR_W-1:0] a, input logic stored);
    logic b;
    b = stored;
    if ((BYPASS != 0) && WE4 && (A4 == a))
      b = 1'b0;
    return b;
  endfunction

  // Port 4 assignment comes last so it wins an address collision with port 3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs <= '0;
    end else begin
      if (WE3 && !is_zero(A3))
        regs[A3] <= WD3;
      if (WE4 && !is_zero(A4))
        regs[A4] <= WD4;
    end
  end

  // A claim is younger than a same-cycle retirement, so the set follows the clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy <= '0;
    end else begin
      if (WE4)
        busy[A4] <= 1'b0;
      if (CLAIM && !is_zero(CA))
        busy[CA] <= 1'b1;
    end
  end

  // Bypass paths would otherwise leak write data through while reset is held.
  always_comb begin
    RD1      = '0;
    RD2      = '0;
    BUSY1    = 1'b0;
    BUSY2    = 1'b0;
    BUSY_ANY = 1'b0;
    if (RST_N) begin
      RD1      = rd_sel(A1, regs[A1]);
      RD2      = rd_sel(A2, regs[A2]);
      BUSY1    = busy_sel(A1, busy[A1]);
      BUSY2    = busy_sel(A2, busy[A2]);
      BUSY_ANY = |busy;
    end
  end

endmodule

// File: doc/regfile_2w_scoreboard.md
Name: regfile_2w_scoreboard

Overview:
- Parametrised successor to the single-write-port CPU register file.
- Two read ports and two write ports: port 3 for ALU writeback, port 4 for load/long-latency return.
- Optional hardwired zero register and same-cycle write-to-read bypass.
- Per-register busy scoreboard so the decode stage can stall on pending loads.
- Sits between decode (reads) and writeback (writes) in the pipelined core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NREGS = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy
BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
A1  in  ADDR_W  read address, port 1
A2  in  ADDR_W  read address, port 2
RD1  out  DATA_W  read data, port 1
RD2  out  DATA_W  read data, port 2
BUSY1  out  1  register at A1 has a pending write
BUSY2  out  1  register at A2 has a pending write
WE3  in  1  write enable, ALU port
A3  in  ADDR_W  write address, ALU port
WD3  in  DATA_W  write data, ALU port
WE4  in  1  write enable, load-return port
A4  in  ADDR_W  write address, load-return port
WD4  in  DATA_W  write data, load-return port
CLAIM  in  1  mark register CA pending
CA  in  ADDR_W  register to mark pending
BUSY_ANY  out  1  OR of all busy bits

Behaviour:
- Reset: RST_N low asynchronously clears all NREGS registers to 0 and all busy bits to 0. It overrides any in-flight write or claim. With reset asserted, RD1/RD2 read 0 and BUSY1/BUSY2/BUSY_ANY read 0.
- Writes:
  - Registered on the CLK rising edge. WE3 writes WD3 to A3; WE4 writes WD4 to A4.
  - Both enabled with A3 == A4: WD4 is stored; port 4 has priority.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads (combinational), for RD1/A1 and likewise RD2/A2:
  - ZERO_REG=1 and A1 == 0: RD1 = 0.
  - Else if BYPASS=1 and WE4 and A4 == A1: RD1 = WD4.
  - Else if BYPASS=1 and WE3 and A3 == A1: RD1 = WD3.
  - Else RD1 = stored value.
  - BYPASS=0: RD1 is the stored value only; the new value is visible the cycle after the edge.
- Scoreboard:
  - busy[CA] is set at the edge when CLAIM=1.
  - busy[A4] is cleared at the edge when WE4=1. WE3 never changes busy.
  - CLAIM and WE4 on the same address in the same cycle: busy ends set, because the claim is younger.
  - ZERO_REG=1: CLAIM to address 0 is ignored.
- Busy outputs:
  - BUSY1 = busy[A1], except BYPASS=1 with WE4 and A4 == A1 in the same cycle forces BUSY1 = 0. BUSY2 likewise.
  - BUSY_ANY = OR of the stored busy bits; no bypass.
- Timing: writes take effect one edge later; reads have zero latency. No internal state other than the registers and busy bits.
- Widths: no arithmetic; all addresses are full-range, so there is no out-of-range case.

Test Plan:
- Reset: RST_N=0 mid-cycle, after writes and claims -> all RD 0, all BUSY 0 immediately. After release, A1=7 gives RD1=0.
- Basic write: WE3=1, A3=5, WD3=0xDEADBEEF, one edge. Then A1=5 -> RD1=0xDEADBEEF. Also A1=A2=5 -> both outputs equal.
- Bypass: WE3=1, A3=9, WD3=0x11; same cycle A1=9 -> RD1=0x11 before the edge. With BYPASS=0 -> RD1 = old value, then 0x11 after the edge.
- Write priority: WE3=1, WE4=1, A3=A4=12, WD3=0xAAAA, WD4=0x5555 -> after the edge RD1(A1=12)=0x5555. Same cycle with BYPASS=1 -> RD1=0x5555.
- Zero register: ZERO_REG=1, WE3=1, A3=0, WD3=0xFFFF, plus CLAIM CA=0 -> RD1(A1=0)=0, BUSY1=0, BUSY_ANY=0.
- Scoreboard:
  - CLAIM CA=3 -> BUSY1(A1=3)=1, BUSY_ANY=1.
  - Next cycle WE4 A4=3 WD4=0x42 -> BUSY1=0 and RD1=0x42 same cycle; busy bit clear after the edge.
  - Simultaneous CLAIM CA=3 with WE4 A4=3 -> busy stays 1.
